// File: rtl/host_cmd_pkg.sv
// Shared constants and types for the host command master: frame opcodes, command
// encodings, frame lengths and the sequencer state enum.
package host_cmd_pkg;

  localparam logic [7:0] OpWrite  = 8'hAA;
  localparam logic [7:0] OpRead   = 8'hBB;
  localparam logic [7:0] OpAluOp  = 8'hCC;
  localparam logic [7:0] OpAluNop = 8'hDD;

  typedef enum logic [1:0] {
    CmdWrite  = 2'd0,
    CmdRead   = 2'd1,
    CmdAluOp  = 2'd2,
    CmdAluNop = 2'd3
  } cmd_type_e;

  localparam int unsigned LenWrite  = 3;
  localparam int unsigned LenRead   = 2;
  localparam int unsigned LenAluOp  = 4;
  localparam int unsigned LenAluNop = 2;

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StWaitHi,
    StWaitLo,
    StResp,
    StDone
  } state_e;

  // Index of the final byte of a frame for the given command.
  function automatic logic [1:0] frame_last(input cmd_type_e t);
    logic [1:0] last;
    unique case (t)
      CmdWrite:  last = 2'(LenWrite - 1);
      CmdRead:   last = 2'(LenRead - 1);
      CmdAluOp:  last = 2'(LenAluOp - 1);
      default:   last = 2'(LenAluNop - 1);
    endcase
    return last;
  endfunction

endpackage

// File: rtl/rsp_timer.sv
// Response timeout counter: counts enabled cycles, saturates, and flags when the
// count equals a nonzero limit.
module rsp_timer #(
  parameter int unsigned TMO_WD = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic [TMO_WD-1:0] limit,
  output logic              hit
);

  logic [TMO_WD-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (en && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign hit = (limit != '0) && (count_q == limit);

endmodule

// File: rtl/host_cmd_master.sv
// Serialises host commands into UART byte frames and gathers the reply bytes.
// Define HOST_CMD_TIMEOUT_EN to enable the response timeout (rsp_timer).
module host_cmd_master
  import host_cmd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TMO_WD     = 16
) (
  input  logic                    clk,
  input  logic                    RST,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_type,
  input  logic [3:0]              cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_data,
  input  logic [DATA_WIDTH-1:0]   cmd_op_a,
  input  logic [DATA_WIDTH-1:0]   cmd_op_b,
  input  logic [3:0]              cmd_fun,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic                    tx_valid,
  input  logic                    tx_busy,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic                    rx_valid,
  output logic [2*DATA_WIDTH-1:0] rsp_data,
  output logic                    rsp_valid,
  output logic                    rsp_timeout,
  output logic                    busy,
  input  logic [TMO_WD-1:0]       timeout_limit
);

  state_e                  state_q, state_d;
  cmd_type_e               type_q;
  logic [3:0]              addr_q, fun_q;
  logic [DATA_WIDTH-1:0]   data_q, op_a_q, op_b_q;
  logic [1:0]              idx_q, idx_d;
  logic                    rx_hi_q, rx_hi_d;
  logic [2*DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [DATA_WIDTH-1:0]   cur_byte;
  logic                    accept, last_byte, tmo_hit;

  assign cmd_ready = (state_q == StIdle);
  assign busy      = ~cmd_ready;
  assign accept    = cmd_valid && cmd_ready;
  assign last_byte = (idx_q == frame_last(type_q));
  assign rsp_data  = rsp_data_q;
  assign tx_data   = tx_valid ? cur_byte : '0;

  always_comb begin
    cur_byte = '0;
    unique case (type_q)
      CmdWrite: begin
        unique case (idx_q)
          2'd0:    cur_byte = DATA_WIDTH'(OpWrite);
          2'd1:    cur_byte = DATA_WIDTH'(addr_q);
          default: cur_byte = data_q;
        endcase
      end
      CmdRead:  cur_byte = (idx_q == 2'd0) ? DATA_WIDTH'(OpRead) : DATA_WIDTH'(addr_q);
      CmdAluOp: begin
        unique case (idx_q)
          2'd0:    cur_byte = DATA_WIDTH'(OpAluOp);
          2'd1:    cur_byte = op_a_q;
          2'd2:    cur_byte = op_b_q;
          default: cur_byte = DATA_WIDTH'(fun_q);
        endcase
      end
      default:  cur_byte = (idx_q == 2'd0) ? DATA_WIDTH'(OpAluNop) : DATA_WIDTH'(fun_q);
    endcase
  end

`ifdef HOST_CMD_TIMEOUT_EN
  rsp_timer #(
    .TMO_WD(TMO_WD)
  ) u_rsp_timer (
    .clk  (clk),
    .rst  (RST),
    .clear((state_q != StResp) || rx_valid),
    .en   (state_q == StResp),
    .limit(timeout_limit),
    .hit  (tmo_hit)
  );
`else
  logic unused_timeout_limit;
  assign unused_timeout_limit = ^timeout_limit;
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rx_hi_d     = rx_hi_q;
    rsp_data_d  = rsp_data_q;
    tx_valid    = 1'b0;
    rsp_valid   = 1'b0;
    rsp_timeout = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d    = StSend;
          idx_d      = 2'd0;
          rx_hi_d    = 1'b0;
          rsp_data_d = '0;
        end
      end
      StSend: begin
        if (!tx_busy) begin
          tx_valid = 1'b1;
          state_d  = StWaitHi;
        end
      end
      StWaitHi: begin
        if (tx_busy) state_d = StWaitLo;
      end
      StWaitLo: begin
        if (!tx_busy) begin
          if (last_byte) begin
            state_d = (type_q == CmdWrite) ? StDone : StResp;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = StSend;
          end
        end
      end
      StResp: begin
        // A reply byte on the timeout cycle takes priority over the timeout.
        if (rx_valid) begin
          if (rx_hi_q) rsp_data_d[DATA_WIDTH +: DATA_WIDTH] = rx_data;
          else         rsp_data_d[DATA_WIDTH-1:0]           = rx_data;
          rx_hi_d = 1'b1;
          if ((type_q == CmdRead) || rx_hi_q) state_d = StDone;
        end else if (tmo_hit) begin
          rsp_timeout = 1'b1;
          state_d     = StIdle;
        end
      end
      StDone: begin
        rsp_valid = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q    <= StIdle;
      type_q     <= CmdWrite;
      addr_q     <= '0;
      fun_q      <= '0;
      data_q     <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      idx_q      <= '0;
      rx_hi_q    <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rx_hi_q    <= rx_hi_d;
      rsp_data_q <= rsp_data_d;
      if (accept) begin
        type_q <= cmd_type_e'(cmd_type);
        addr_q <= cmd_addr;
        fun_q  <= cmd_fun;
        data_q <= cmd_data;
        op_a_q <= cmd_op_a;
        op_b_q <= cmd_op_b;
      end
    end
  end

endmodule

// File: tb/tb_host_cmd_master.sv
// Directed self-checking bench for host_cmd_master with a 10-cycle-per-byte UART
// TX busy model.
module tb_host_cmd_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_type = '0;
  logic [3:0]  cmd_addr = '0;
  logic [7:0]  cmd_data = '0, cmd_op_a = '0, cmd_op_b = '0;
  logic [3:0]  cmd_fun = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_busy = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_valid, rsp_timeout, busy;
  logic [15:0] timeout_limit = '0;

  always #5 clk = ~clk;

  host_cmd_master #(
    .DATA_WIDTH(8),
    .TMO_WD    (16)
  ) dut (
    .clk          (clk),
    .RST          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_type     (cmd_type),
    .cmd_addr     (cmd_addr),
    .cmd_data     (cmd_data),
    .cmd_op_a     (cmd_op_a),
    .cmd_op_b     (cmd_op_b),
    .cmd_fun      (cmd_fun),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_busy      (tx_busy),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rsp_data     (rsp_data),
    .rsp_valid    (rsp_valid),
    .rsp_timeout  (rsp_timeout),
    .busy         (busy),
    .timeout_limit(timeout_limit)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] tx_log[$];
  int         viol = 0;
  int         n_rsp = 0;
  int         n_tmo = 0;
  logic       force_busy = 1'b0;
  int         bcnt = 0;

  // UART model: busy for 10 cycles after each accepted byte.
  always @(posedge clk) begin
    if (tx_valid) tx_log.push_back(tx_data);
    if (tx_valid && tx_busy) viol <= viol + 1;
    if (rsp_valid) n_rsp <= n_rsp + 1;
    if (rsp_timeout) n_tmo <= n_tmo + 1;
    if (force_busy) begin
      tx_busy <= 1'b1;
      bcnt    <= 0;
    end else if (tx_valid) begin
      tx_busy <= 1'b1;
      bcnt    <= 9;
    end else if (bcnt > 0) begin
      bcnt <= bcnt - 1;
    end else begin
      tx_busy <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input logic [1:0] t, input logic [3:0] a, input logic [7:0] d,
                       input logic [7:0] oa, input logic [7:0] ob, input logic [3:0] f);
    cmd_type  = t;
    cmd_addr  = a;
    cmd_data  = d;
    cmd_op_a  = oa;
    cmd_op_b  = ob;
    cmd_fun   = f;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (tx_log.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // kind 0 waits for rsp_valid, kind 1 for rsp_timeout; gap counts cycles since the
  // last tx_busy fall.
  task automatic wait_evt(input int kind, input int max, output bit seen, output int gap);
    logic prev;
    int   fall;
    prev = tx_busy;
    fall = 0;
    seen = 1'b0;
    gap  = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (prev && !tx_busy) fall = i;
      prev = tx_busy;
      if ((kind == 0 && rsp_valid) || (kind == 1 && rsp_timeout)) begin
        seen = 1'b1;
        gap  = i - fall;
        break;
      end
    end
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  initial begin
    bit ok;
    int gap, snap;

    // Reset values
    tick(3);
    chk("rst_busy", busy, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    rst = 1'b0;
    tick(1);
    chk("rst_cmd_ready", cmd_ready, 1);

    // Write addr=3 data=0x5A; a second request while busy must be ignored
    tx_log.delete();
    issue(2'd0, 4'h3, 8'h5A, 8'h00, 8'h00, 4'h0);
    chk("wr_busy", busy, 1);
    chk("wr_cmd_ready", cmd_ready, 0);
    cmd_type  = 2'd1;
    cmd_addr  = 4'h7;
    cmd_valid = 1'b1;
    tick(5);
    cmd_valid = 1'b0;
    wait_evt(0, 200, ok, gap);
    chk("wr_rsp_seen", ok, 1);
    chk("wr_latency", gap, 1);
    chk("wr_rsp_data", rsp_data, 16'h0000);
    chk("wr_tx_len", tx_log.size(), 3);
    if (tx_log.size() == 3) begin
      chk("wr_tx0", tx_log[0], 8'hAA);
      chk("wr_tx1", tx_log[1], 8'h03);
      chk("wr_tx2", tx_log[2], 8'h5A);
    end
    tick(1);
    chk("wr_rsp_pulse", rsp_valid, 0);
    chk("wr_ready_after", cmd_ready, 1);

    // Read addr=2, reply 0x81; a stray rx byte during SEND is ignored
    tx_log.delete();
    issue(2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0);
    rx_pulse(8'hEE);
    wait_tx(2, 200, ok);
    chk("rd_tx_done", ok, 1);
    tick(15);
    chk("rd_wait_resp", busy, 1);
    chk("rd_no_early_rsp", rsp_valid, 0);
    rx_pulse(8'h81);
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_data", rsp_data, 16'h0081);
    chk("rd_tx0", tx_log[0], 8'hBB);
    chk("rd_tx1", tx_log[1], 8'h02);
    tick(1);
    chk("rd_rsp_pulse", rsp_valid, 0);

    // ALU with operands, reply LSB first
    tx_log.delete();
    issue(2'd2, 4'h0, 8'h00, 8'h10, 8'h20, 4'h2);
    wait_tx(4, 300, ok);
    chk("alu_tx_done", ok, 1);
    tick(15);
    rx_pulse(8'h00);
    tick(3);
    chk("alu_half_rsp", rsp_valid, 0);
    chk("alu_half_busy", busy, 1);
    rx_pulse(8'h02);
    chk("alu_rsp_valid", rsp_valid, 1);
    chk("alu_rsp_data", rsp_data, 16'h0200);
    chk("alu_tx0", tx_log[0], 8'hCC);
    chk("alu_tx1", tx_log[1], 8'h10);
    chk("alu_tx2", tx_log[2], 8'h20);
    chk("alu_tx3", tx_log[3], 8'h02);
    tick(1);

    // Reset during the second byte of an ALU-nop frame
    tx_log.delete();
    issue(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h5);
    wait_tx(2, 200, ok);
    chk("nop_tx_done", ok, 1);
    snap = n_rsp;
    rst = 1'b1;
    tick(1);
    chk("abort_busy", busy, 0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_tx_valid", tx_valid, 0);
    chk("abort_rsp_data", rsp_data, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    rst = 1'b0;
    tick(40);
    chk("abort_no_rsp", n_rsp, snap);
    chk("abort_idle", busy, 0);
    chk("nop_tx1", tx_log[1], 8'h05);

    // tx_busy stuck high: no byte may be sent
    force_busy = 1'b1;
    tick(2);
    tx_log.delete();
    issue(2'd1, 4'h4, 8'h00, 8'h00, 8'h00, 4'h0);
    tick(20);
    chk("stuck_no_tx", tx_log.size(), 0);
    chk("stuck_busy", busy, 1);
    rst = 1'b1;
    tick(1);
    chk("stuck_abort", busy, 0);
    rst = 1'b0;
    force_busy = 1'b0;
    tick(3);

    // Read with no reply
    snap = n_rsp;
    tx_log.delete();
`ifdef HOST_CMD_TIMEOUT_EN
    timeout_limit = 16'd50;
    issue(2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0);
    wait_evt(1, 300, ok, gap);
    chk("tmo_seen", ok, 1);
    // RESP is entered one cycle after the final busy fall
    chk("tmo_latency", gap, 51);
    tick(1);
    chk("tmo_pulse", rsp_timeout, 0);
    chk("tmo_ready", cmd_ready, 1);
    chk("tmo_no_rsp", n_rsp, snap);
    timeout_limit = 16'd0;
`else
    timeout_limit = 16'd50;
    issue(2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0);
    tick(150);
    chk("notmo_none", n_tmo, 0);
    chk("notmo_busy", busy, 1);
    chk("notmo_no_rsp", n_rsp, snap);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    timeout_limit = 16'd0;
    tick(1);
    chk("notmo_ready", cmd_ready, 1);
`endif

    chk("tx_valid_while_busy", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
